right_shift_receiver: RTL and testbench
=======================================

# right_shift_receiver

Serial-in, parallel-out receiver forming the far end of the right-shift serial link. The transmitter is a parallel-load right-shift register that emits its LSB first, one bit per enabled clock. This block shifts the incoming bits in from the MSB side so each word reappears in its original bit order. Completed words are held in a one-deep output buffer with a valid/ready handshake, and lost words are flagged by a sticky overrun bit.

## Interface
- WIDTH, 4, word width in bits; legal range ≥ 2.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sin  input  1  serial data bit, sampled only when shift_en is high.
- shift_en  input  1  bit-valid strobe; one bit is accepted per clock it is high.
- sync  input  1  frame realign; discards any partial word and restarts at bit 0.
- q_ready  input  1  consumer accepts q this cycle.
- ovr_clr  input  1  clears the sticky overrun flag.
- q  output  WIDTH  last completed word, held stable while q_valid is high.
- q_valid  output  1  q holds an unconsumed word.
- busy  output  1  a partial word is in progress (bit count ≠ 0).
- overrun  output  1  sticky; a completed word was dropped because the buffer was full.

## Operation
- Shift path: when a bit is accepted, shreg <= {sin, shreg[WIDTH-1:1]}.
  - The first bit received ends up in shreg[0] after WIDTH accepted bits.
- Bit counter cnt has width $clog2(WIDTH). It counts 0..WIDTH-1 and wraps to 0 on the bit that completes a word.
- FSM states, encoded by the counter:
  - IDLE: cnt = 0, busy = 0.
  - SHIFT: cnt in 1..WIDTH-1, busy = 1.
  - IDLE -> SHIFT on an accepted bit.
  - SHIFT -> IDLE on the WIDTH-th bit or on sync.
- Word completion, on the edge that accepts bit WIDTH-1, with word = {sin, shreg[WIDTH-1:1]}:
  - If the buffer is empty, or q_valid && q_ready in the same cycle: q <= word, q_valid <= 1.
  - Otherwise: the word is dropped, q and q_valid are unchanged, and overrun <= 1.
- Consumption: q_valid && q_ready with no completion on the same edge gives q_valid <= 0. q holds its last value.
- sync with shift_en in the same cycle: the partial word is discarded and sin is taken as bit 0 of the new word (cnt <= 1).
- sync without shift_en: cnt <= 0. shreg contents are don't-care because they are fully overwritten before the next completion.
- sync never affects q, q_valid or overrun.
- overrun stays set until ovr_clr is asserted. If ovr_clr and a new overrun occur on the same edge, set wins and overrun stays 1.
- shift_en low: no change to shreg or cnt. Gaps between bits are unlimited.

## Timing
- Reset values: q = 0, q_valid = 0, busy = 0, overrun = 0, cnt = 0, shreg = 0.
- rst overrides every other input, including in mid-word and while q_valid is high; the pending word is lost.
- Latency: q and q_valid update on the same edge that samples the last bit, so they are visible in the following cycle. There are no extra pipeline stages.
- Maximum throughput is one word every WIDTH clocks with shift_en held high. There is no overrun as long as q_ready is high on every completion cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- A shared package rsr_pkg holds:
  - the default WIDTH constant;
  - the counter-width localparam derived from $clog2(WIDTH);
  - the IDLE/SHIFT status encoding, shared with the transmitter bench.
- One sub-module, sipo_shift_core, contains shreg, cnt and the completion pulse (word_done, word).
- The top level adds the output buffer, the handshake and the overrun logic.

## Test plan
- Reset, then idle with no shift_en: all outputs stay 0 and busy = 0.
- Transmitter-matching word, WIDTH = 4, q_ready = 1: feed sin = 1,0,1,1 on four consecutive shift_en cycles. Required: q = 4'b1101 and q_valid = 1 after the 4th edge, busy = 0. q_valid drops one cycle later.
- Back-to-back words with q_ready held at 0: feed 1101 then 0110. Required: q stays 4'b1101 with q_valid = 1 and overrun = 1. Then pulse ovr_clr with no other activity: overrun returns to 0.
- Completion on the same edge as consumption: q_valid = 1 holding 1101, q_ready = 1 on the cycle bit 3 of 0011 arrives. Required: q = 4'b0011, q_valid remains 1, overrun = 0.
- Realign: send bits 1,1, then sync together with shift_en and sin = 0, then sin = 1,0,1. Required: q = 4'b1010 and busy = 0 after the last bit.
- rst mid-word after 2 bits and again while q_valid = 1: all outputs return to reset values on the next edge. The following clean word 1001 is received correctly.

Source files
------------

// File: rtl/rsr_pkg.sv
// rsr_pkg: shared constants and status encoding for the right-shift serial link.
package rsr_pkg;
    localparam int RSR_WIDTH = 4;
    localparam int RSR_CNT_W = $clog2(RSR_WIDTH);
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} rsr_state_t;
endpackage

// File: rtl/sipo_shift_core.sv
// sipo_shift_core: MSB-side shift register and bit counter, pulses word_done with the assembled word.
module sipo_shift_core
    import rsr_pkg::*;
#(
    parameter int WIDTH = RSR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             shift_en,
    input  logic             sync,
    output logic [WIDTH-1:0] word,
    output logic             word_done,
    output rsr_state_t       state
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    // Bit 0 is never read back: a completed word is forwarded straight from sin.
    logic [WIDTH-1:1] shreg;
    logic [CW-1:0]    cnt, cnt_next;
    always_comb begin
        word      = {sin, shreg};
        word_done = shift_en && !sync && cnt == LAST;
        state     = cnt == '0 ? IDLE : SHIFT;
        cnt_next  = sync ? (shift_en ? CW'(1) : '0)
                  : shift_en ? (word_done ? '0 : cnt + 1'b1) : cnt;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else begin
            if (shift_en) shreg <= word[WIDTH-1:1];
            cnt <= cnt_next;
        end
    end
endmodule

// File: rtl/right_shift_receiver.sv
// right_shift_receiver: serial-in receiver with a one-deep valid/ready output buffer and sticky overrun.
module right_shift_receiver
    import rsr_pkg::*;
#(
    parameter int WIDTH = RSR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             shift_en,
    input  logic             sync,
    input  logic             q_ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             busy,
    output logic             overrun
);
    logic [WIDTH-1:0] word;
    logic             word_done;
    rsr_state_t       state;
    logic             take, drop;
    sipo_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .sin      (sin),
        .shift_en (shift_en),
        .sync     (sync),
        .word     (word),
        .word_done(word_done),
        .state    (state)
    );
    assign busy = state == SHIFT;
    always_comb begin
        take = word_done && (!q_valid || q_ready);
        drop = word_done && q_valid && !q_ready;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            q_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (take) begin
                q       <= word;
                q_valid <= 1'b1;
            end else if (q_valid && q_ready) begin
                q_valid <= 1'b0;
            end
            // A new drop outranks a simultaneous clear.
            if (drop) overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_right_shift_receiver.sv
// tb_right_shift_receiver: directed vectors with hand-computed results for right_shift_receiver (WIDTH = 4).
module tb_right_shift_receiver;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sin = 1'b0;
    logic       shift_en = 1'b0;
    logic       sync = 1'b0;
    logic       q_ready = 1'b0;
    logic       ovr_clr = 1'b0;
    logic [3:0] q;
    logic       q_valid, busy, overrun;
    int         checks = 0;
    int         errors = 0;

    right_shift_receiver #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .sin     (sin),
        .shift_en(shift_en),
        .sync    (sync),
        .q_ready (q_ready),
        .ovr_clr (ovr_clr),
        .q       (q),
        .q_valid (q_valid),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic s, input logic e, input logic y, input logic r, input logic c);
        sin = s;
        shift_en = e;
        sync = y;
        q_ready = r;
        ovr_clr = c;
        @(posedge clk);
        #1;
    endtask

    // Send w LSB first; r applies to bits 0..2, r_last/c_last to the completing bit.
    task automatic send(input logic [3:0] w, input logic r, input logic r_last, input logic c_last);
        for (int i = 0; i < 3; i++) step(w[i], 1'b1, 1'b0, r, 1'b0);
        step(w[3], 1'b1, 1'b0, r_last, c_last);
    endtask

    task automatic outs(input string tag, input logic [3:0] eq, input logic ev, input logic eb, input logic eo);
        chk({tag, ".q"}, q, eq);
        chk({tag, ".q_valid"}, q_valid, ev);
        chk({tag, ".busy"}, busy, eb);
        chk({tag, ".overrun"}, overrun, eo);
    endtask

    initial begin
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        rst = 1'b0;
        outs("reset", 4'h0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 1, 0);
        outs("idle", 4'h0, 0, 0, 0);

        step(1, 1, 0, 1, 0);
        chk("first_bit.busy", busy, 1);
        step(0, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        outs("word1101", 4'b1101, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        outs("consume", 4'b1101, 0, 0, 0);

        send(4'b1101, 0, 0, 0);
        outs("hold1101", 4'b1101, 1, 0, 0);
        send(4'b0110, 0, 0, 0);
        outs("overrun", 4'b1101, 1, 0, 1);
        step(0, 0, 0, 0, 1);
        outs("ovr_clr", 4'b1101, 1, 0, 0);

        send(4'b0011, 0, 1, 0);
        outs("same_edge", 4'b0011, 1, 0, 0);
        send(4'b1111, 0, 0, 1);
        outs("set_wins", 4'b0011, 1, 0, 1);
        step(0, 0, 0, 1, 1);
        outs("clr_consume", 4'b0011, 0, 0, 0);

        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        step(0, 1, 1, 1, 0);
        chk("sync_en.busy", busy, 1);
        step(1, 1, 0, 1, 0);
        step(0, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        outs("realign", 4'b1010, 1, 0, 0);

        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        outs("sync_only", 4'b1010, 0, 0, 0);
        send(4'b0101, 1, 1, 0);
        outs("after_sync", 4'b0101, 1, 0, 0);
        send(4'b1110, 1, 1, 0);
        outs("back_to_back", 4'b1110, 1, 0, 0);

        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        rst = 1'b1;
        step(1, 1, 0, 0, 0);
        rst = 1'b0;
        outs("rst_midword", 4'h0, 0, 0, 0);
        send(4'b0111, 0, 0, 0);
        chk("pre_rst.q_valid", q_valid, 1);
        rst = 1'b1;
        step(0, 0, 0, 0, 0);
        rst = 1'b0;
        outs("rst_valid", 4'h0, 0, 0, 0);
        send(4'b1001, 1, 1, 0);
        outs("post_rst", 4'b1001, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
